// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI register slave.
package spi_reg_pkg;

    localparam int unsigned SPI_FRAME_BITS = 40;
    localparam int unsigned SPI_CMD_BITS   = 8;
    localparam int unsigned SPI_ABITS      = 7;
    localparam int unsigned SPI_DBITS      = 32;
    localparam int unsigned SPI_CNT_BITS   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with an extra history flop for edge detection.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic q_prev
);

    logic meta;

    // Resynchronize the pin and keep one cycle of history behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= RESET_VAL;
            q      <= RESET_VAL;
            q_prev <= RESET_VAL;
        end else begin
            meta   <= d;
            q      <= meta;
            q_prev <= q;
        end
    end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave: 1 R/W bit, address, data; issues register read/write strobes.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned ABITS = SPI_ABITS,
    parameter int unsigned DBITS = SPI_DBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SPI_CSL,
    input  logic             SPI_SCLK,
    input  logic             SPI_MOSI,
    output logic             SPI_MISO,
    output logic             we,
    output logic             re,
    output logic [ABITS-1:0] addr,
    output logic [DBITS-1:0] wdata,
    input  logic [DBITS-1:0] rdata
);

    localparam int unsigned CW = SPI_CNT_BITS;
    localparam logic [CW-1:0] CMD_LAST   = CW'(SPI_CMD_BITS - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(SPI_FRAME_BITS - 1);
    localparam logic [CW-1:0] FRAME_END  = CW'(SPI_FRAME_BITS);

    logic csl, csl_prev;
    logic sclk, sclk_prev;
    logic mosi_now, mosi;

    spi_sync #(.RESET_VAL(1'b1)) u_sync_csl (
        .clk    (clk),
        .reset  (reset),
        .d      (SPI_CSL),
        .q      (csl),
        .q_prev (csl_prev)
    );

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .d      (SPI_SCLK),
        .q      (sclk),
        .q_prev (sclk_prev)
    );

    // MOSI is taken from the history flop: it is one cycle older than the
    // detected SCLK edge, so it was settled well before the pin rose.
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .d      (SPI_MOSI),
        .q      (mosi_now),
        .q_prev (mosi)
    );

    logic rise, fall, csl_fall;
    assign rise     = sclk & ~sclk_prev;
    assign fall     = ~sclk & sclk_prev;
    assign csl_fall = ~csl & csl_prev;

    state_t                  state, state_next;
    logic [CW-1:0]           bitcnt, bitcnt_next;
    logic [SPI_CMD_BITS-2:0] cmd, cmd_next;
    logic [SPI_CMD_BITS-1:0] cmd_shift;
    logic                    rw, rw_next;
    logic [ABITS-1:0]        addr_next;
    logic [DBITS-1:0]        wdata_next;
    logic [DBITS-1:0]        tx, tx_next;
    logic                    re_d, re_d_next;
    logic                    re_next, we_next, miso_next;

    assign cmd_shift = {cmd, mosi};

    // State register and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bitcnt   <= '0;
            cmd      <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            tx       <= '0;
            re_d     <= 1'b0;
            re       <= 1'b0;
            we       <= 1'b0;
            SPI_MISO <= 1'b0;
        end else begin
            state    <= state_next;
            bitcnt   <= bitcnt_next;
            cmd      <= cmd_next;
            rw       <= rw_next;
            addr     <= addr_next;
            wdata    <= wdata_next;
            tx       <= tx_next;
            re_d     <= re_d_next;
            re       <= re_next;
            we       <= we_next;
            SPI_MISO <= miso_next;
        end
    end

    // Next-state and output logic for the frame sequencer.
    always_comb begin
        state_next  = state;
        bitcnt_next = bitcnt;
        cmd_next    = cmd;
        rw_next     = rw;
        addr_next   = addr;
        wdata_next  = wdata;
        tx_next     = tx;
        miso_next   = SPI_MISO;
        re_next     = 1'b0;
        we_next     = 1'b0;
        re_d_next   = re;

        // Parent read data is captured the cycle after re so its side effects see re first.
        if (re_d) begin
            tx_next = rdata;
        end

        case (state)
            IDLE: begin
                bitcnt_next = '0;
                miso_next   = 1'b0;
                if (csl_fall) begin
                    state_next = CMD;
                end
            end

            CMD: begin
                if (csl) begin
                    state_next = IDLE;
                    miso_next  = 1'b0;
                end else if (rise) begin
                    cmd_next    = cmd_shift[SPI_CMD_BITS-2:0];
                    bitcnt_next = bitcnt + CW'(1);
                    if (bitcnt == CMD_LAST) begin
                        rw_next    = cmd_shift[SPI_CMD_BITS-1];
                        addr_next  = cmd_shift[ABITS-1:0];
                        re_next    = cmd_shift[SPI_CMD_BITS-1];
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (csl) begin
                    state_next = IDLE;
                    miso_next  = 1'b0;
                end else if (rw && fall) begin
                    miso_next = tx[DBITS-1];
                    tx_next   = {tx[DBITS-2:0], 1'b0};
                end
                // Rises are still honoured in the cycle CSL goes high so a
                // just-completed write is not lost.
                if (rise && (bitcnt != FRAME_END)) begin
                    bitcnt_next = bitcnt + CW'(1);
                    if (!rw) begin
                        wdata_next = {wdata[DBITS-2:0], mosi};
                        if (bitcnt == FRAME_LAST) begin
                            we_next = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
                miso_next  = 1'b0;
            end
        endcase
    end

endmodule
